// File: rtl/camera_capture_core.sv
// camera_capture_core: DVP byte-to-pixel capture with frame/line tracking; define CAMCAP_SHORT_LINE_EN to build the short-line check
module camera_capture_core #(
  parameter int BYTES_PER_PIX  = 2,
  parameter int MAX_LINE_BYTES = 1568,
  parameter int X_W            = 11,
  parameter int Y_W            = 10,
  parameter int BCNT_W         = 12
) (
  input  logic                       PCLK,
  input  logic                       reset,
  input  logic                       cap_en,
  input  logic                       CamVsync,
  input  logic                       CamHsync,
  input  logic [7:0]                 CamData_in,
  output logic [8*BYTES_PER_PIX-1:0] pix_data,
  output logic                       pix_valid,
  output logic                       pix_sof,
  output logic [X_W-1:0]             pix_x,
  output logic [Y_W-1:0]             pix_y,
  output logic                       line_end,
  output logic                       frame_done,
  output logic [Y_W-1:0]             frame_lines,
  output logic                       line_ovf,
  output logic                       short_line_err
);
  localparam int PW = 8 * BYTES_PER_PIX;
  localparam logic [BCNT_W-1:0] MAXB = BCNT_W'(MAX_LINE_BYTES);
  localparam logic [1:0] LASTP = 2'(BYTES_PER_PIX - 1);
  typedef enum logic [1:0] {S_IDLE, S_VBLANK, S_ACTIVE} state_t;
  state_t st, ns;
  logic vs_q, hs_q, vs_p, hs_p;
  logic [7:0] d_q;
  logic [PW-1:0] pack, pack_nxt;
  logic [BCNT_W-1:0] bcnt;
  logic [1:0] phase;
  logic [X_W-1:0] x_cnt;
  logic [Y_W-1:0] line_cnt, line_inc, line_nxt;
  logic sof_pend;
  logic vs_rise, vs_fall, hs_fall, act, take, keep, emit, line_evt, frame_evt, start;
  always_ff @(posedge PCLK)
    st <= reset ? S_IDLE : ns;
  always_comb begin
    ns = st;
    ns = st == S_IDLE   ? (vs_q ? S_VBLANK : S_IDLE) :
         st == S_VBLANK ? (vs_fall ? (cap_en ? S_ACTIVE : S_IDLE) : S_VBLANK) :
                          (vs_rise ? S_VBLANK : S_ACTIVE);
  end
  always_comb begin
    vs_rise   = vs_q & ~vs_p;
    vs_fall   = ~vs_q & vs_p;
    hs_fall   = ~hs_q & hs_p;
    act       = st == S_ACTIVE;
    take      = act & hs_q;
    keep      = take & (bcnt < MAXB);
    emit      = keep & (phase == LASTP);
    line_evt  = act & hs_fall;
    frame_evt = act & vs_rise;
    start     = (st == S_VBLANK) & vs_fall & cap_en;
    pack_nxt  = PW'({pack, d_q});
    line_inc  = &line_cnt ? line_cnt : line_cnt + 1'b1;
    line_nxt  = line_evt ? line_inc : line_cnt;
  end
  always_ff @(posedge PCLK) begin
    if (reset) begin
      {vs_q, hs_q, vs_p, hs_p, d_q} <= '0;
      {pack, bcnt, phase, x_cnt, line_cnt, sof_pend} <= '0;
      {pix_data, pix_valid, pix_sof, pix_x, pix_y} <= '0;
      {line_end, frame_done, frame_lines, line_ovf} <= '0;
    end else begin
      vs_q       <= CamVsync;
      hs_q       <= CamHsync;
      d_q        <= CamData_in;
      vs_p       <= vs_q;
      hs_p       <= hs_q;
      pix_valid  <= emit;
      pix_sof    <= emit & sof_pend;
      line_end   <= line_evt;
      frame_done <= frame_evt;
      if (emit) begin
        pix_data <= pack_nxt;
        pix_x    <= x_cnt;
        pix_y    <= line_cnt;
        sof_pend <= 1'b0;
        x_cnt    <= x_cnt + 1'b1;
      end
      if (keep) begin
        pack  <= pack_nxt;
        bcnt  <= bcnt + 1'b1;
        phase <= emit ? 2'd0 : phase + 2'd1;
      end
      if (take & ~keep)
        line_ovf <= 1'b1;
      if (line_evt) begin
        bcnt     <= '0;
        phase    <= '0;
        x_cnt    <= '0;
        line_cnt <= line_inc;
      end
      if (frame_evt)
        frame_lines <= line_nxt;
      if (start) begin
        bcnt     <= '0;
        phase    <= '0;
        x_cnt    <= '0;
        line_cnt <= '0;
        line_ovf <= 1'b0;
        sof_pend <= 1'b1;
      end
    end
  end
`ifdef CAMCAP_SHORT_LINE_EN
  logic [X_W-1:0] first_px;
  always_ff @(posedge PCLK) begin
    if (reset) begin
      first_px       <= '0;
      short_line_err <= 1'b0;
    end else if (start) begin
      short_line_err <= 1'b0;
    end else if (line_evt) begin
      if (line_cnt == '0)
        first_px <= x_cnt;
      else if (x_cnt != first_px)
        short_line_err <= 1'b1;
    end
  end
`else
  assign short_line_err = 1'b0;
`endif
endmodule

// File: tb/tb_camera_capture_core.sv
// tb_camera_capture_core: scoreboard bench for camera_capture_core with BYTES_PER_PIX=2, MAX_LINE_BYTES=8
module tb_camera_capture_core;
  localparam int MAXB = 8;
  typedef struct packed {
    logic [15:0] d;
    logic [10:0] x;
    logic [9:0]  y;
    logic        sof;
  } pix_t;
  logic PCLK = 1'b0;
  logic reset = 1'b1;
  logic cap_en = 1'b1;
  logic CamVsync = 1'b0;
  logic CamHsync = 1'b0;
  logic [7:0] CamData_in = 8'h00;
  logic [15:0] pix_data;
  logic pix_valid, pix_sof, line_end, frame_done, line_ovf, short_line_err;
  logic [10:0] pix_x;
  logic [9:0] pix_y, frame_lines;
  int checks = 0;
  int errors = 0;
  int n_pix = 0;
  int n_le = 0;
  int n_fd = 0;
  int cur_y = 0;
  bit sof_next = 1'b0;
  pix_t q[$];
  camera_capture_core #(
    .BYTES_PER_PIX(2), .MAX_LINE_BYTES(MAXB), .X_W(11), .Y_W(10), .BCNT_W(12)
  ) dut (
    .PCLK(PCLK), .reset(reset), .cap_en(cap_en), .CamVsync(CamVsync),
    .CamHsync(CamHsync), .CamData_in(CamData_in), .pix_data(pix_data),
    .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_x(pix_x), .pix_y(pix_y),
    .line_end(line_end), .frame_done(frame_done), .frame_lines(frame_lines),
    .line_ovf(line_ovf), .short_line_err(short_line_err)
  );
  always #5 PCLK = ~PCLK;
  always @(negedge PCLK) begin
    pix_t exp_p, got_p;
    if (pix_valid) begin
      n_pix++;
      checks++;
      got_p = {pix_data, pix_x, pix_y, pix_sof};
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pixel got data=%h x=%0d y=%0d sof=%b, none expected", pix_data, pix_x, pix_y, pix_sof);
      end else begin
        exp_p = q.pop_front();
        if (got_p !== exp_p) begin
          errors++;
          $display("FAIL pixel got data=%h x=%0d y=%0d sof=%b exp data=%h x=%0d y=%0d sof=%b",
                   pix_data, pix_x, pix_y, pix_sof, exp_p.d, exp_p.x, exp_p.y, exp_p.sof);
        end
      end
    end
    if (line_end) n_le++;
    if (frame_done) n_fd++;
  end
  task automatic drive_line(input int n, input bit cap);
    int k;
    pix_t e;
    k = n > MAXB ? MAXB : n;
    if (cap) begin
      for (int i = 0; i + 1 < k; i += 2) begin
        e.d = {8'(i), 8'(i + 1)};
        e.x = 11'(i / 2);
        e.y = 10'(cur_y);
        e.sof = sof_next;
        sof_next = 1'b0;
        q.push_back(e);
      end
      cur_y++;
    end
    for (int i = 0; i < n; i++) begin
      @(negedge PCLK);
      CamHsync = 1'b1;
      CamData_in = 8'(i);
    end
    @(negedge PCLK);
    CamHsync = 1'b0;
    repeat (3) @(negedge PCLK);
  endtask
  task automatic start_frame();
    @(negedge PCLK);
    CamVsync = 1'b0;
    cur_y = 0;
    sof_next = 1'b1;
    repeat (3) @(negedge PCLK);
  endtask
  task automatic vsync_high();
    @(negedge PCLK);
    CamVsync = 1'b1;
    repeat (4) @(negedge PCLK);
  endtask
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge PCLK);
    checks++;
    if ({pix_data, pix_valid, pix_sof, pix_x, pix_y} !== '0) begin
      errors++;
      $display("FAIL reset_pix got data=%h v=%b sof=%b x=%0d y=%0d exp all 0", pix_data, pix_valid, pix_sof, pix_x, pix_y);
    end
    checks++;
    if ({line_end, frame_done, frame_lines, line_ovf, short_line_err} !== '0) begin
      errors++;
      $display("FAIL reset_status got le=%b fd=%b fl=%0d ovf=%b sle=%b exp all 0", line_end, frame_done, frame_lines, line_ovf, short_line_err);
    end
    reset = 1'b0;
  endtask
  task automatic test_midframe_start();
    drive_line(8, 1'b0);
    drive_line(8, 1'b0);
    vsync_high();
    drive_line(4, 1'b0);
    checks++;
    if (n_pix !== 0 || n_le !== 0 || n_fd !== 0) begin
      errors++;
      $display("FAIL midframe got pix=%0d le=%0d fd=%0d exp 0 0 0", n_pix, n_le, n_fd);
    end
  endtask
  task automatic test_frame();
    int le0, fd0;
    le0 = n_le;
    fd0 = n_fd;
    start_frame();
    repeat (4) drive_line(8, 1'b1);
    vsync_high();
    checks++;
    if (n_fd - fd0 !== 1) begin errors++; $display("FAIL frame_done_count got %0d exp 1", n_fd - fd0); end
    checks++;
    if (n_le - le0 !== 4) begin errors++; $display("FAIL line_end_count got %0d exp 4", n_le - le0); end
    checks++;
    if (frame_lines !== 10'd4) begin errors++; $display("FAIL frame_lines got %0d exp 4", frame_lines); end
    checks++;
    if (q.size() !== 0) begin errors++; $display("FAIL frame_pixels_missing got %0d left exp 0", q.size()); end
    checks++;
    if (line_ovf !== 1'b0) begin errors++; $display("FAIL frame_ovf got %b exp 0", line_ovf); end
  endtask
  task automatic test_short_pixel();
    start_frame();
    drive_line(7, 1'b1);
    drive_line(8, 1'b1);
    vsync_high();
    checks++;
    if (q.size() !== 0) begin errors++; $display("FAIL odd_line_pixels got %0d left exp 0", q.size()); end
    checks++;
    if (frame_lines !== 10'd2) begin errors++; $display("FAIL odd_frame_lines got %0d exp 2", frame_lines); end
  endtask
  task automatic test_overflow();
    start_frame();
    drive_line(12, 1'b1);
    checks++;
    if (line_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", line_ovf); end
    drive_line(8, 1'b1);
    vsync_high();
    checks++;
    if (line_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", line_ovf); end
    checks++;
    if (q.size() !== 0) begin errors++; $display("FAIL ovf_pixels got %0d left exp 0", q.size()); end
  endtask
  task automatic test_cap_en();
    int p0, le0, fd0;
    p0 = n_pix;
    le0 = n_le;
    fd0 = n_fd;
    cap_en = 1'b0;
    start_frame();
    drive_line(8, 1'b0);
    drive_line(8, 1'b0);
    vsync_high();
    checks++;
    if (n_pix - p0 !== 0 || n_le - le0 !== 0 || n_fd - fd0 !== 0) begin
      errors++;
      $display("FAIL cap_off got pix=%0d le=%0d fd=%0d exp 0 0 0", n_pix - p0, n_le - le0, n_fd - fd0);
    end
    checks++;
    if (frame_lines !== 10'd2) begin errors++; $display("FAIL cap_off_held_lines got %0d exp 2", frame_lines); end
    cap_en = 1'b1;
    start_frame();
    checks++;
    if (line_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", line_ovf); end
    drive_line(8, 1'b1);
    cap_en = 1'b0;
    drive_line(8, 1'b1);
    drive_line(4, 1'b1);
    vsync_high();
    cap_en = 1'b1;
    checks++;
    if (frame_lines !== 10'd3) begin errors++; $display("FAIL cap_on_lines got %0d exp 3", frame_lines); end
    checks++;
    if (q.size() !== 0) begin errors++; $display("FAIL cap_on_pixels got %0d left exp 0", q.size()); end
  endtask
  task automatic test_reset_midframe();
    int p0, le0;
    start_frame();
    @(negedge PCLK);
    CamHsync = 1'b1;
    CamData_in = 8'h55;
    @(negedge PCLK);
    reset = 1'b1;
    p0 = n_pix;
    le0 = n_le;
    repeat (2) @(negedge PCLK);
    reset = 1'b0;
    CamHsync = 1'b0;
    checks++;
    if (frame_lines !== 10'd0) begin errors++; $display("FAIL rst_mid_lines got %0d exp 0", frame_lines); end
    drive_line(8, 1'b0);
    drive_line(8, 1'b0);
    checks++;
    if (n_pix - p0 !== 0 || n_le - le0 !== 0) begin
      errors++;
      $display("FAIL rst_mid_capture got pix=%0d le=%0d exp 0 0", n_pix - p0, n_le - le0);
    end
    vsync_high();
  endtask
  task automatic test_short_line();
    logic exp_err;
`ifdef CAMCAP_SHORT_LINE_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    start_frame();
    drive_line(8, 1'b1);
    drive_line(8, 1'b1);
    checks++;
    if (short_line_err !== 1'b0) begin errors++; $display("FAIL short_before got %b exp 0", short_line_err); end
    drive_line(6, 1'b1);
    checks++;
    if (short_line_err !== exp_err) begin errors++; $display("FAIL short_after got %b exp %b", short_line_err, exp_err); end
    vsync_high();
    checks++;
    if (short_line_err !== exp_err) begin errors++; $display("FAIL short_sticky got %b exp %b", short_line_err, exp_err); end
    start_frame();
    checks++;
    if (short_line_err !== 1'b0) begin errors++; $display("FAIL short_clear got %b exp 0", short_line_err); end
    drive_line(8, 1'b1);
    vsync_high();
    checks++;
    if (q.size() !== 0) begin errors++; $display("FAIL short_pixels got %0d left exp 0", q.size()); end
  endtask
  initial begin
    test_reset();
    test_midframe_start();
    test_frame();
    test_short_pixel();
    test_overflow();
    test_cap_en();
    test_reset_midframe();
    test_frame();
    test_short_line();
    repeat (5) @(negedge PCLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
